// File: rtl/id_hazard_controller_pkg.sv
// Shared opcode constants, FSM state type and stall limit for the ID-stage hazard controller.
package id_hazard_controller_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned MAX_STALL = 2;

    localparam logic [OP_W-1:0] OP_RTYPE  = 6'b000000;
    localparam logic [OP_W-1:0] OP_REGIMM = 6'b000001;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE    = 6'b000101;
    localparam logic [OP_W-1:0] OP_BLEZ   = 6'b000110;
    localparam logic [OP_W-1:0] OP_BGTZ   = 6'b000111;
    localparam logic [OP_W-1:0] OP_ADDI   = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU  = 6'b001001;
    localparam logic [OP_W-1:0] OP_SLTI   = 6'b001010;
    localparam logic [OP_W-1:0] OP_SLTIU  = 6'b001011;
    localparam logic [OP_W-1:0] OP_ANDI   = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI    = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI   = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI    = 6'b001111;
    localparam logic [OP_W-1:0] OP_LB     = 6'b100000;
    localparam logic [OP_W-1:0] OP_LH     = 6'b100001;
    localparam logic [OP_W-1:0] OP_LW     = 6'b100011;

    localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'b001000;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_operand_decode.sv
// Maps the ID instruction's opcode/funct to which source registers it reads and whether it is a branch or jr.
import id_hazard_controller_pkg::*;

module hazard_operand_decode (
    input  logic [OP_W-1:0]    i_opcode,
    input  logic [FUNCT_W-1:0] i_funct,
    output logic               o_uses_rs,
    output logic               o_uses_rt,
    output logic               o_is_branch,
    output logic               o_is_jr
);

    always_comb begin
        o_uses_rs   = 1'b1;
        o_uses_rt   = 1'b1;
        o_is_branch = 1'b0;
        o_is_jr     = 1'b0;
        case (i_opcode)
            OP_BEQ, OP_BNE: begin
                o_is_branch = 1'b1;
            end
            OP_REGIMM, OP_BLEZ, OP_BGTZ: begin
                o_is_branch = 1'b1;
                o_uses_rt   = 1'b0;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW: begin
                o_uses_rt = 1'b0;
            end
            OP_RTYPE: begin
                if (i_funct == FUNCT_JR) begin
                    o_is_jr   = 1'b1;
                    o_uses_rt = 1'b0;
                end
            end
            default: begin
                o_uses_rt = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_hazard_controller.sv
// ID-stage stall/flush sequencer: load-use and branch-operand stalls, taken-branch/jr IF/ID flush.
// Optional HAZARD_PERF_EN adds saturating StallCycles/FlushCount counters.
import id_hazard_controller_pkg::*;

module id_hazard_controller #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [OP_W-1:0]    IFID_Opcode,
    input  logic [FUNCT_W-1:0] IFID_Funct,
    input  logic [REG_W-1:0]   IFID_Rs,
    input  logic [REG_W-1:0]   IFID_Rt,
    input  logic               IDEX_RegWrite,
    input  logic               IDEX_MemRead,
    input  logic [REG_W-1:0]   IDEX_Rd,
    input  logic               EXMEM_MemRead,
    input  logic [REG_W-1:0]   EXMEM_Rd,
    input  logic               BranchTaken,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               IDEX_Bubble,
    output logic               IFID_Flush,
    output logic               Stalling
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        StallCycles,
    output logic [31:0]        FlushCount
`endif
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_uses_rs;
    logic               w_uses_rt;
    logic               w_is_branch;
    logic               w_is_jr;
    logic               w_ex_match;
    logic               w_mem_match;
    logic [CNT_W-1:0]   w_need;
    logic [CNT_W-1:0]   w_need_m1;

    hazard_operand_decode u_decode (
        .i_opcode    (IFID_Opcode),
        .i_funct     (IFID_Funct),
        .o_uses_rs   (w_uses_rs),
        .o_uses_rt   (w_uses_rt),
        .o_is_branch (w_is_branch),
        .o_is_jr     (w_is_jr)
    );

    // $0 is hardwired, so a zero destination never produces a dependency
    assign w_ex_match  = (IDEX_Rd != '0) &&
                         ((w_uses_rs && (IFID_Rs == IDEX_Rd)) ||
                          (w_uses_rt && (IFID_Rt == IDEX_Rd)));
    assign w_mem_match = (EXMEM_Rd != '0) &&
                         ((w_uses_rs && (IFID_Rs == EXMEM_Rd)) ||
                          (w_uses_rt && (IFID_Rt == EXMEM_Rd)));

    // Branch/jr compare in ID, so even an ALU result in EX is too late; EX producer wins over MEM
    always_comb begin
        w_need = '0;
        if (r_state == RUN) begin
            if (w_is_branch || w_is_jr) begin
                if (IDEX_MemRead && w_ex_match) begin
                    w_need = CNT_W'(MAX_STALL);
                end else if (IDEX_RegWrite && w_ex_match) begin
                    w_need = CNT_W'(1);
                end else if (EXMEM_MemRead && w_mem_match) begin
                    w_need = CNT_W'(1);
                end
            end else if (IDEX_MemRead && w_ex_match) begin
                w_need = CNT_W'(1);
            end
        end
    end

    assign w_need_m1 = w_need - CNT_W'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_need != '0) begin
                        r_cnt   <= w_need_m1;
                        r_state <= (w_need_m1 != '0) ? STALL : RUN;
                    end
                end
                STALL: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Zero-latency control outputs; reset forces the free-running pipeline values
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        Stalling    = 1'b0;
        if (!Reset) begin
            if ((r_state != RUN) || (w_need != '0)) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEX_Bubble = 1'b1;
                Stalling    = 1'b1;
            end else if ((w_is_branch && BranchTaken) || w_is_jr) begin
                IFID_Flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (IDEX_Bubble && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (IFID_Flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
`endif

endmodule

// File: tb/tb_id_hazard_controller.sv
// Scoreboard bench for id_hazard_controller: directed pipeline vectors, expected outputs queued per cycle.
module tb_id_hazard_controller;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [5:0] IFID_Opcode;
    logic [5:0] IFID_Funct;
    logic [4:0] IFID_Rs;
    logic [4:0] IFID_Rt;
    logic       IDEX_RegWrite;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_Rd;
    logic       EXMEM_MemRead;
    logic [4:0] EXMEM_Rd;
    logic       BranchTaken;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IDEX_Bubble;
    logic       IFID_Flush;
    logic       Stalling;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles;
    logic [31:0] FlushCount;
`endif

    id_hazard_controller #(.REG_W(5), .CNT_W(2)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .IFID_Opcode   (IFID_Opcode),
        .IFID_Funct    (IFID_Funct),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_Rd       (IDEX_Rd),
        .EXMEM_MemRead (EXMEM_MemRead),
        .EXMEM_Rd      (EXMEM_Rd),
        .BranchTaken   (BranchTaken),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IDEX_Bubble   (IDEX_Bubble),
        .IFID_Flush    (IFID_Flush),
        .Stalling      (Stalling)
`ifdef HAZARD_PERF_EN
        ,
        .StallCycles   (StallCycles),
        .FlushCount    (FlushCount)
`endif
    );

    always #5 Clk = ~Clk;

    // expected = {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Stalling}
    localparam logic [4:0] E_RUN   = 5'b11000;
    localparam logic [4:0] E_STALL = 5'b00101;
    localparam logic [4:0] E_FLUSH = 5'b11010;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] JR  = 6'b001000;

    string      name_q[$];
    logic [4:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_stalls = 0;
    int         exp_flushes = 0;

    // Drive one ID-stage cycle and queue the outputs it should produce
    task automatic vec(input string nm, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic rw, input logic mr, input logic [4:0] rd,
                       input logic emr, input logic [4:0] erd, input logic bt,
                       input logic [4:0] exp);
        @(posedge Clk);
        #1;
        Reset = rst; IFID_Opcode = op; IFID_Funct = fn; IFID_Rs = rs; IFID_Rt = rt;
        IDEX_RegWrite = rw; IDEX_MemRead = mr; IDEX_Rd = rd;
        EXMEM_MemRead = emr; EXMEM_Rd = erd; BranchTaken = bt;
        if (rst) begin
            exp_stalls  = 0;
            exp_flushes = 0;
        end else begin
            exp_stalls  += int'(exp[2]);
            exp_flushes += int'(exp[1]);
        end
        name_q.push_back(nm);
        exp_q.push_back(exp);
    endtask

    // Monitor: compare whenever a queued expectation is pending, mid-cycle
    initial begin
        string      nm;
        logic [4:0] ex;
        logic [4:0] act;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                nm  = name_q.pop_front();
                ex  = exp_q.pop_front();
                act = {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Stalling};
                n_checks++;
                if (act === ex) n_pass++;
                else $display("FAIL %s: got %b expected %b (PCW,IFW,BUB,FLU,STL)", nm, act, ex);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; IFID_Opcode = '0; IFID_Funct = '0; IFID_Rs = '0; IFID_Rt = '0;
        IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0; IDEX_Rd = '0;
        EXMEM_MemRead = 1'b0; EXMEM_Rd = '0; BranchTaken = 1'b0;

        //   name              rst op   fn   rs  rt  rw  mr  rd  emr erd bt  exp
        vec("reset_forced",    1, RT,  ADD, 8,  2,  1,  1,  8,  0,  0,  0,  E_RUN);
        vec("idle",            0, RT,  ADD, 1,  2,  0,  0,  0,  0,  0,  0,  E_RUN);
        // lw $8 ; add $9,$8,$2
        vec("lu_stall",        0, RT,  ADD, 8,  2,  1,  1,  8,  0,  0,  0,  E_STALL);
        vec("lu_resume",       0, RT,  ADD, 8,  2,  0,  0,  0,  1,  8,  0,  E_RUN);
        // lw $8 ; beq $8,$3 taken
        vec("br_lw_s1",        0, BEQ, 0,   8,  3,  1,  1,  8,  0,  0,  1,  E_STALL);
        vec("br_lw_s2",        0, BEQ, 0,   8,  3,  0,  0,  0,  1,  8,  1,  E_STALL);
        vec("br_lw_flush",     0, BEQ, 0,   8,  3,  0,  0,  0,  0,  0,  1,  E_FLUSH);
        vec("after_flush",     0, RT,  ADD, 1,  2,  0,  0,  0,  0,  0,  0,  E_RUN);
        // addi $5 ; bne $5,$0
        vec("br_alu_stall",    0, BNE, 0,   5,  0,  1,  0,  5,  0,  0,  0,  E_STALL);
        vec("br_alu_resume",   0, BNE, 0,   5,  0,  0,  0,  0,  0,  5,  0,  E_RUN);
        vec("br_rd0_flush",    0, BNE, 0,   5,  0,  1,  0,  0,  0,  0,  1,  E_FLUSH);
        // addi $4,$7,1 vs lw $4 (rt only), then sw $4,0($7)
        vec("itype_rt_only",   0, ADI, 0,   7,  4,  1,  1,  4,  0,  0,  0,  E_RUN);
        vec("sw_stall",        0, SW,  0,   7,  4,  1,  1,  4,  0,  0,  0,  E_STALL);
        vec("sw_resume",       0, SW,  0,   7,  4,  0,  0,  0,  1,  4,  0,  E_RUN);
        vec("zero_reg",        0, RT,  ADD, 0,  0,  1,  1,  0,  0,  0,  0,  E_RUN);
        // EX and MEM both match: EX ALU wins -> 1 stall only
        vec("ex_mem_prio",     0, BEQ, 0,   6,  2,  1,  0,  6,  1,  6,  0,  E_STALL);
        vec("ex_mem_resume",   0, BEQ, 0,   6,  2,  0,  0,  0,  0,  6,  0,  E_RUN);
        vec("br_mem_load",     0, BEQ, 0,   3,  9,  0,  0,  0,  1,  3,  1,  E_STALL);
        vec("br_mem_resume",   0, BEQ, 0,   3,  9,  0,  0,  0,  0,  0,  1,  E_FLUSH);
        // jr ignores rt; jr behind a load stalls twice then flushes
        vec("jr_rt_ignored",   0, RT,  JR,  31, 5,  1,  0,  5,  0,  0,  0,  E_FLUSH);
        vec("jr_lw_s1",        0, RT,  JR,  31, 0,  1,  1,  31, 0,  0,  0,  E_STALL);
        vec("jr_lw_s2",        0, RT,  JR,  31, 0,  0,  0,  0,  0,  0,  0,  E_STALL);
        vec("jr_lw_flush",     0, RT,  JR,  31, 0,  0,  0,  0,  0,  0,  0,  E_FLUSH);
        // reset during second stall cycle
        vec("rst_mid_s1",      0, BEQ, 0,   8,  3,  1,  1,  8,  0,  0,  1,  E_STALL);
        vec("rst_mid_forced",  1, BEQ, 0,   8,  3,  0,  0,  0,  1,  8,  1,  E_RUN);
        vec("rst_release",     0, RT,  ADD, 1,  2,  0,  0,  0,  0,  0,  0,  E_RUN);
        // lw-use branch scenario three times for the counters
        for (int k = 0; k < 3; k++) begin
            vec("rep_s1",      0, BEQ, 0,   8,  3,  1,  1,  8,  0,  0,  1,  E_STALL);
            vec("rep_s2",      0, BEQ, 0,   8,  3,  0,  0,  0,  1,  8,  1,  E_STALL);
            vec("rep_flush",   0, BEQ, 0,   8,  3,  0,  0,  0,  0,  0,  1,  E_FLUSH);
        end
        vec("final_idle",      0, RT,  ADD, 1,  2,  0,  0,  0,  0,  0,  0,  E_RUN);

        repeat (4) @(posedge Clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
`ifdef HAZARD_PERF_EN
        @(negedge Clk);
        n_checks++;
        if (StallCycles == 32'(exp_stalls)) n_pass++;
        else $display("FAIL stall_cycles: got %0d expected %0d", StallCycles, exp_stalls);
        n_checks++;
        if (FlushCount == 32'(exp_flushes)) n_pass++;
        else $display("FAIL flush_count: got %0d expected %0d", FlushCount, exp_flushes);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
